// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_ctrl_pkg
// Brief  : Shared encodings, defaults and request check for dmem_access_ctrl.
// Rev    : 1.0
// ============================================================================
package dmem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int RD_LAT_DEF    = 3;
    localparam int ADDR_BITS_DEF = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Only the byte offset is kept; the word address goes straight to mem_addr.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } acc_t;

    function automatic logic req_invalid(input logic [1:0] size, input logic [31:0] addr,
                                         input int addr_bits);
        logic bad_align;
        logic bad_range;
        bad_align = ((size == SIZE_H) && addr[0]) ||
                    ((size == SIZE_W) && (addr[1:0] != 2'b00));
        bad_range = (addr >> addr_bits) != 32'd0;
        return (size == 2'b11) || bad_align || bad_range;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_req_if / dmem_mem_if
// Brief  : Requester-side and memory-side bundles of dmem_access_ctrl.
// Rev    : 1.0
// ============================================================================
interface dmem_req_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, size, uns, addr, wdata,
                    input  gnt, done, rdata, err);
    modport slave  (input  req, we, size, uns, addr, wdata,
                    output gnt, done, rdata, err);
endinterface

interface dmem_mem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic        en;
    logic [31:0] rdata;

    modport master (output addr, wdata, rw, en, input rdata);
    modport slave  (input  addr, wdata, rw, en, output rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Store lane merge and load extract/extend for one 32-bit word.
// Rev    : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [31:0] i_wdata,
    input  wire logic [1:0]  i_off,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_uns,
    output logic      [31:0] o_merged,
    output logic      [31:0] o_extracted
);
    logic [4:0]  w_sh;
    logic [31:0] w_shifted;
    logic [31:0] w_mask;

    assign w_sh      = {i_off, 3'b000};
    assign w_shifted = i_word >> w_sh;

    always_comb begin
        w_mask      = 32'hFFFF_FFFF;
        o_extracted = w_shifted;
        case (i_size)
            SIZE_B: begin
                w_mask      = 32'h0000_00FF << w_sh;
                o_extracted = {{24{w_shifted[7] & ~i_uns}}, w_shifted[7:0]};
            end
            SIZE_H: begin
                w_mask      = 32'h0000_FFFF << w_sh;
                o_extracted = {{16{w_shifted[15] & ~i_uns}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_access_ctrl
// Brief  : Two-port arbiter/sequencer for the banked word-wide data memory,
//          with read-modify-write sub-word stores. DMEM_CTRL_RR_EN selects
//          round-robin arbitration, otherwise A has fixed priority over B.
// Rev    : 1.0
// ============================================================================
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dmem_req_if.slave  a,
    dmem_req_if.slave  b,
    dmem_mem_if.master mem
);
    localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_t             acc_q, acc_d;
    logic             owner_q, owner_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_rw_q, mem_rw_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_pick_b;
    logic             w_any_req;
    logic             w_idle;
    acc_t             w_win;
    logic [31:0]      w_win_addr;
    logic [31:0]      w_merged;
    logic [31:0]      w_extracted;

`ifdef DMEM_CTRL_RR_EN
    logic rr_ptr_q, rr_ptr_d;
    assign w_pick_b = b.req && (!a.req || rr_ptr_q);
`else
    assign w_pick_b = b.req && !a.req;
`endif

    assign w_any_req  = a.req || b.req;
    assign w_idle     = (state_q == IDLE);
    assign w_win_addr = w_pick_b ? b.addr : a.addr;

    always_comb begin
        if (w_pick_b) begin
            w_win = '{we: b.we, size: b.size, uns: b.uns, off: b.addr[1:0], wdata: b.wdata};
        end else begin
            w_win = '{we: a.we, size: a.size, uns: a.uns, off: a.addr[1:0], wdata: a.wdata};
        end
    end

    // Fed straight from mem.rdata so the merge/extract lands in the capture cycle.
    dmem_lane_align u_lane_align (
        .i_word      (mem.rdata),
        .i_wdata     (acc_q.wdata),
        .i_off       (acc_q.off),
        .i_size      (acc_q.size),
        .i_uns       (acc_q.uns),
        .o_merged    (w_merged),
        .o_extracted (w_extracted)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef DMEM_CTRL_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    acc_d   = w_win;
                    owner_d = w_pick_b;
`ifdef DMEM_CTRL_RR_EN
                    rr_ptr_d = !w_pick_b;
`endif
                    if (req_invalid(w_win.size, w_win_addr, ADDR_BITS)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_addr_d  = {2'b00, w_win_addr[31:2]};
                        mem_rw_d    = w_win.we && (w_win.size == SIZE_W);
                        mem_wdata_d = w_win.we ? w_win.wdata : '0;
                    end
                end
            end
            ISSUE: begin
                if (acc_q.we && (acc_q.size == SIZE_W)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (acc_q.we) begin
                        state_d     = WRITE;
                        mem_en_d    = 1'b1;
                        mem_rw_d    = 1'b1;
                        mem_wdata_d = w_merged;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = w_extracted;
                    end
                end
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef DMEM_CTRL_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef DMEM_CTRL_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Grant is decided combinationally in IDLE; masking with rst keeps it low during reset.
    assign a.gnt   = w_idle && a.req && !w_pick_b && !rst;
    assign b.gnt   = w_idle && w_pick_b && !rst;
    assign a.done  = done_q && !owner_q;
    assign b.done  = done_q && owner_q;
    assign a.rdata = rdata_q;
    assign b.rdata = rdata_q;
    assign a.err   = err_q;
    assign b.err   = err_q;

    assign mem.en    = mem_en_q;
    assign mem.rw    = mem_rw_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_access_ctrl
// Brief  : Directed self-checking bench for dmem_access_ctrl with a
//          3-cycle-latency memory model.
// Rev    : 1.0
// ============================================================================
module tb_dmem_access_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_req_if ia ();
    dmem_req_if ib ();
    dmem_mem_if im ();

    dmem_access_ctrl #(.RD_LAT(RD_LAT), .ADDR_BITS(15)) dut (
        .clk (clk),
        .rst (rst),
        .a   (ia),
        .b   (ib),
        .mem (im)
    );

    // Memory model: en/addr register, bank read, output register.
    logic [31:0] mem_arr [0:8191];
    logic [31:0] pipe1, pipe2, rd_q;
    always @(posedge clk) begin
        if (im.en && im.rw) mem_arr[im.addr[12:0]] <= im.wdata;
        pipe1 <= (im.en && !im.rw) ? mem_arr[im.addr[12:0]] : 32'hBAD0_BAD0;
        pipe2 <= pipe1;
        rd_q  <= pipe2;
    end
    assign im.rdata = rd_q;

    int          en_cnt     = 0;
    int          done_cnt   = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_raddr = '0;
    always @(posedge clk) begin
        if (im.en) en_cnt <= en_cnt + 1;
        if (im.en && im.rw) begin
            last_waddr <= im.addr;
            last_wdata <= im.wdata;
        end
        if (im.en && !im.rw) last_raddr <= im.addr;
        if (ia.done || ib.done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            ib.req = req; ib.we = we; ib.size = size; ib.uns = uns; ib.addr = addr; ib.wdata = wdata;
        end else begin
            ia.req = req; ia.we = we; ia.size = size; ia.uns = uns; ia.addr = addr; ia.wdata = wdata;
        end
    endtask

    // One transaction on one port; lat counts cycles from the gnt cycle to the done cycle.
    task automatic access(input bit port, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic e, output int lat);
        bit seen;
        bit fin;
        seen = 1'b0; fin = 1'b0; lat = -1; rd = '0; e = 1'b0;
        @(negedge clk);
        drive(port, 1'b1, we, size, uns, addr, wdata);
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            if (!seen && (port ? ib.gnt : ia.gnt)) begin
                seen = 1'b1;
                lat  = 0;
            end else if (seen) begin
                lat++;
            end
            if (port ? ib.done : ia.done) begin
                fin = 1'b1;
                rd  = port ? ib.rdata : ia.rdata;
                e   = port ? ib.err : ia.err;
            end else begin
                @(negedge clk);
            end
        end
        drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        chk("timeout", 32'(fin), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          e0, d0, na, nb, n;
        logic [3:0]  order;
        logic [3:0]  exp_order;

        // Reset: outputs stay 0 even with a request pending.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, SIZE_W, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt_a", 32'(ia.gnt), 32'd0);
        chk("rst_done", 32'({ia.done, ib.done, ia.err}), 32'd0);
        chk("rst_mem_en", 32'({im.en, im.rw}), 32'd0);
        chk("rst_rdata", ia.rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, SIZE_W, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then word load through bank 0.
        access(1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, rd, e, lat);
        chk("wst_lat", 32'(lat), 32'd2);
        chk("wst_rdata", rd, 32'd0);
        chk("wst_err", 32'(e), 32'd0);
        chk("wst_addr", last_waddr, 32'h0000_0101);
        chk("wst_wdata", last_wdata, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0000_0404, 32'd0, rd, e, lat);
        chk("wld_addr", last_raddr, 32'h0000_0101);
        chk("wld_rdata", rd, 32'hDEAD_BEEF);
        chk("wld_lat", 32'(lat), 32'(RD_LAT + 2));

        // Byte read-modify-write into the top lane.
        access(1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_2000, 32'h1122_3344, rd, e, lat);
        access(1'b0, 1'b1, SIZE_B, 1'b0, 32'h0000_2003, 32'h0000_005A, rd, e, lat);
        chk("bst_lat", 32'(lat), 32'(RD_LAT + 3));
        chk("bst_wdata", last_wdata, 32'h5A22_3344);
        chk("bst_addr", last_waddr, 32'h0000_0800);
        access(1'b0, 1'b0, SIZE_B, 1'b0, 32'h0000_2003, 32'd0, rd, e, lat);
        chk("bld_s", rd, 32'h0000_005A);
        access(1'b0, 1'b0, SIZE_H, 1'b0, 32'h0000_2002, 32'd0, rd, e, lat);
        chk("hld_hi", rd, 32'h0000_5A22);
        access(1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_2000, 32'd0, rd, e, lat);
        chk("b_wld", rd, 32'h5A22_3344);
        chk("b_wld_lat", 32'(lat), 32'(RD_LAT + 2));

        // Sign versus zero extension.
        access(1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_0010, 32'h0000_80FF, rd, e, lat);
        access(1'b0, 1'b0, SIZE_H, 1'b0, 32'h0000_0010, 32'd0, rd, e, lat);
        chk("hld_s", rd, 32'hFFFF_80FF);
        access(1'b0, 1'b0, SIZE_H, 1'b1, 32'h0000_0010, 32'd0, rd, e, lat);
        chk("hld_u", rd, 32'h0000_80FF);
        access(1'b0, 1'b0, SIZE_B, 1'b0, 32'h0000_0010, 32'd0, rd, e, lat);
        chk("bld_neg", rd, 32'hFFFF_FFFF);

        // Invalid requests: no memory access, done one cycle after gnt.
        e0 = en_cnt;
        access(1'b0, 1'b0, SIZE_H, 1'b0, 32'h0000_0001, 32'd0, rd, e, lat);
        chk("err_h_mis", 32'(e), 32'd1);
        chk("err_h_lat", 32'(lat), 32'd1);
        access(1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_0002, 32'd0, rd, e, lat);
        chk("err_w_mis", 32'(e), 32'd1);
        access(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0000_8000, 32'd0, rd, e, lat);
        chk("err_range", 32'(e), 32'd1);
        chk("err_range_lat", 32'(lat), 32'd1);
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0, rd, e, lat);
        chk("err_size", 32'(e), 32'd1);
        chk("err_no_en", 32'(en_cnt), 32'(e0));

        // Reset in the WAIT phase of a byte store.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, SIZE_B, 1'b0, 32'h0000_0010, 32'h0000_00AA);
        #1;
        chk("rmw_gnt", 32'(ia.gnt), 32'd1);
        @(negedge clk);
        @(negedge clk);
        e0 = en_cnt;
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("arst_flags", 32'({ia.gnt, ia.done, ia.err, im.en, im.rw}), 32'd0);
        chk("arst_addr", im.addr, 32'd0);
        chk("arst_wdata", im.wdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, SIZE_W, 1'b0, 32'd0, 32'd0);
        repeat (6) @(negedge clk);
        chk("arst_no_en", 32'(en_cnt), 32'(e0));
        chk("arst_no_done", 32'(done_cnt), 32'(d0));
        rst = 1'b0;

        // Both ports request two loads each, starting from a fresh pointer.
        na = 2; nb = 2; n = 0; order = '0;
`ifdef DMEM_CTRL_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1100;
`endif
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0404, 32'd0);
        drive(1'b1, 1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_2000, 32'd0);
        for (int c = 0; c < 100 && (na > 0 || nb > 0); c++) begin
            #1;
            if (ia.gnt && n < 4) begin order[n] = 1'b0; n++; end
            if (ib.gnt && n < 4) begin order[n] = 1'b1; n++; end
            if (ia.done) begin
                chk("arb_a_rdata", ia.rdata, 32'hDEAD_BEEF);
                na--;
                if (na == 0) ia.req = 1'b0;
            end
            if (ib.done) begin
                chk("arb_b_rdata", ib.rdata, 32'h5A22_3344);
                nb--;
                if (nb == 0) ib.req = 1'b0;
            end
            @(negedge clk);
        end
        ia.req = 1'b0;
        ib.req = 1'b0;
        chk("arb_pending", 32'(na + nb), 32'd0);
        chk("arb_order", 32'(order), 32'(exp_order));

        // The aborted byte store must have left the word untouched.
        access(1'b0, 1'b0, SIZE_W, 1'b0, 32'h0000_0010, 32'd0, rd, e, lat);
        chk("arst_mem_kept", rd, 32'h0000_80FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
